// File: rtl/uart_rx_frame_parser_if.sv
// Byte-in / word-out bundle between uart_rx, the frame parser and the host-side consumers.
// master = byte source and result consumer; slave = the parser itself.
interface uart_rx_frame_parser_if #(
    parameter int DATA_WIDTH   = 8,
    parameter int INDATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0]   rx_data;
    logic                    rx_valid;
    logic [INDATA_WIDTH-1:0] data_out;
    logic                    data_valid;
    logic                    frame_err;
    logic [15:0]             err_cnt;
    logic                    busy;

    modport master (
        output rx_data, rx_valid,
        input  data_out, data_valid, frame_err, err_cnt, busy
    );

    modport slave (
        input  rx_data, rx_valid,
        output data_out, data_valid, frame_err, err_cnt, busy
    );
endinterface

// File: rtl/uart_rx_frame_parser.sv
// Recovers [TX_HEADER, BYTE_NUM payload bytes LSB-first, TX_ENDER] frames from a uart_rx byte stream.
// Optional inter-byte timeout: define UART_RX_FRAME_TIMEOUT_EN.
module uart_rx_frame_parser #(
    parameter int                    DATA_WIDTH     = 8,
    parameter int                    INDATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] TX_HEADER      = 8'hFF,
    parameter logic [DATA_WIDTH-1:0] TX_ENDER       = 8'hEE,
    parameter int                    TIMEOUT_CYCLES = 100_000
) (
    input  logic                     clk,
    input  logic                     rst,
    uart_rx_frame_parser_if.slave    rx_if
);
    localparam int BYTE_NUM = INDATA_WIDTH / DATA_WIDTH;
    localparam int IDX_W    = (BYTE_NUM > 1) ? $clog2(BYTE_NUM) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTE_NUM - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BODY  = 2'd1,
        ENDER = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [INDATA_WIDTH-1:0] payload_q, payload_d;
    logic [INDATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                    data_valid_q, data_valid_d;
    logic                    frame_err_q, frame_err_d;
    logic [15:0]             err_cnt_q, err_cnt_d;
    logic                    busy_q, busy_d;
    logic                    err_inc;

`ifdef UART_RX_FRAME_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    // NOTE: every _d is given its hold value first so no path through the case infers a latch.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        payload_d    = payload_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        err_inc      = 1'b0;

        if (rx_if.rx_valid) begin
            unique case (state_q)
                IDLE: begin
                    if (rx_if.rx_data == TX_HEADER) begin
                        state_d = BODY;
                        idx_d   = '0;
                    end
                end
                BODY: begin
                    for (int i = 0; i < BYTE_NUM; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            payload_d[i*DATA_WIDTH +: DATA_WIDTH] = rx_if.rx_data;
                        end
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = ENDER;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                ENDER: begin
                    if (rx_if.rx_data == TX_ENDER) begin
                        data_out_d   = payload_q;
                        data_valid_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        err_inc     = 1'b1;
                        // A header in the ender slot is taken as the start of the next frame.
                        if (rx_if.rx_data == TX_HEADER) begin
                            state_d = BODY;
                            idx_d   = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

`ifdef UART_RX_FRAME_TIMEOUT_EN
        tmo_cnt_d = '0;
        if (state_q != IDLE && !rx_if.rx_valid) begin
            if (tmo_cnt_q == TMO_LAST) begin
                frame_err_d = 1'b1;
                err_inc     = 1'b1;
                state_d     = IDLE;
            end else begin
                tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
            end
        end
`endif

        err_cnt_d = (err_inc && err_cnt_q != 16'hFFFF) ? err_cnt_q + 16'd1 : err_cnt_q;
        busy_d    = (state_d != IDLE);
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            payload_q    <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            err_cnt_q    <= '0;
            busy_q       <= 1'b0;
`ifdef UART_RX_FRAME_TIMEOUT_EN
            tmo_cnt_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            payload_q    <= payload_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
            err_cnt_q    <= err_cnt_d;
            busy_q       <= busy_d;
`ifdef UART_RX_FRAME_TIMEOUT_EN
            tmo_cnt_q    <= tmo_cnt_d;
`endif
        end
    end

    assign rx_if.data_out   = data_out_q;
    assign rx_if.data_valid = data_valid_q;
    assign rx_if.frame_err  = frame_err_q;
    assign rx_if.err_cnt    = err_cnt_q;
    assign rx_if.busy       = busy_q;
endmodule
